dispatch_ctrl: RTL and testbench

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_pkg.sv | 34 +++
 rtl/dispatch_ctrl_if.sv | 24 ++
 rtl/dispatch_ctrl_credit_counter.sv | 36 +++
 rtl/dispatch_ctrl.sv | 107 ++++++++++
 tb/tb_dispatch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch controller: packet layout,
// credit pool sizes, load/store opcode range and FSM states.
package dispatch_pkg;

    localparam int ROB_SIZE = 16;
    localparam int RS_SIZE  = 16;
    localparam int LSQ_SIZE = 16;
    localparam int CNT_W    = 5;

    // Load/store opcodes occupy the contiguous range OP_LB..OP_SW.
    localparam logic [5:0] OP_LB = 6'd10;
    localparam logic [5:0] OP_SW = 6'd17;

    // 85-bit packet, MSB first: inst_type occupies bits 84:79, pc bits 31:0.
    typedef struct packed {
        logic [5:0]  inst_type;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } dec_pkt_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_RECOVER = 2'd2
    } disp_state_e;

    function automatic logic is_ls(input logic [5:0] inst_type);
        return (inst_type >= OP_LB) && (inst_type <= OP_SW);
    endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Decoder-to-dispatch handshake bundle plus the dispatch strobe outputs.
interface dispatch_ctrl_if;
    import dispatch_pkg::*;

    // A packet transfers on a rising edge where dec_valid_in and dec_ready_out are
    // both high; disp_en_out is a one-cycle strobe with no back-pressure.
    logic     dec_valid_in;
    dec_pkt_t dec_pkt_in;
    logic     dec_ready_out;
    logic     disp_en_out;
    dec_pkt_t disp_pkt_out;
    logic     disp_is_ls_out;

    modport master (
        output dec_valid_in, dec_pkt_in,
        input  dec_ready_out, disp_en_out, disp_pkt_out, disp_is_ls_out
    );

    modport slave (
        input  dec_valid_in, dec_pkt_in,
        output dec_ready_out, disp_en_out, disp_pkt_out, disp_is_ls_out
    );

endinterface

// File: rtl/dispatch_ctrl_credit_counter.sv
// Credit counter for one downstream structure: starts full, one credit taken
// per dispatch, one returned per free pulse, refilled on flush.
module credit_counter
    import dispatch_pkg::*;
#(
    parameter int MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             take,
    input  logic             free,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX);

    logic free_eff;

    // A free arriving while already full would overflow the pool, so it is dropped.
    assign free_eff = free && (cnt != FULL);
    assign nonzero  = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= FULL;
        end else if (flush) begin
            cnt <= FULL;
        end else if (en) begin
            cnt <= cnt + CNT_W'(free_eff) - CNT_W'(take);
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: 2-entry packet FIFO gated by ROB/RS/LSQ credits,
// with a RUN/STALL/RECOVER FSM for credit stalls and misprediction flushes.
module dispatch_ctrl
    import dispatch_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             rob_free_in,
    input  logic             rs_free_in,
    input  logic             lsq_free_in,
    dispatch_ctrl_if.slave   bus,
    output logic [1:0]       state_out
);

    disp_state_e      state;
    dec_pkt_t         fifo_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;

    logic             head_valid;
    logic             head_ls;
    logic             live;
    logic             credit_ok;
    logic             accept;
    logic             dispatch;
    logic             rs_take;
    logic             lsq_take;
    logic [CNT_W-1:0] rob_cnt;
    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] lsq_cnt;
    logic             rob_nz;
    logic             rs_nz;
    logic             lsq_nz;

    assign head_valid = (count != 2'd0);
    assign head_ls    = head_valid && is_ls(fifo_mem[rd_ptr].inst_type);
    assign live       = rdy_in && !flush_in && (state != ST_RECOVER);
    assign credit_ok  = rob_nz && (head_ls ? lsq_nz : rs_nz);

    // Ready depends only on occupancy and control, never on credits, so the
    // decoder sees no combinational path from the free inputs.
    assign bus.dec_ready_out  = rst_in && live && (count != 2'd2);
    assign accept             = bus.dec_valid_in && bus.dec_ready_out;
    assign dispatch           = live && head_valid && credit_ok;
    assign rs_take            = dispatch && !head_ls;
    assign lsq_take           = dispatch && head_ls;

    assign bus.disp_en_out    = dispatch;
    assign bus.disp_pkt_out   = head_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.disp_is_ls_out = head_ls;
    assign state_out          = state;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush_in) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (rdy_in) begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (dispatch) rd_ptr <= ~rd_ptr;
            count <= count + 2'(accept) - 2'(dispatch);
        end
    end

    // Storage needs no reset: head contents are only visible while count is nonzero.
    always_ff @(posedge clk_in) begin
        if (accept) fifo_mem[wr_ptr] <= bus.dec_pkt_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_RUN;
        end else if (flush_in) begin
            state <= ST_RECOVER;
        end else if (rdy_in) begin
            case (state)
                ST_RUN:     if (head_valid && !credit_ok) state <= ST_STALL;
                ST_STALL:   if (dispatch) state <= ST_RUN;
                ST_RECOVER: state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

    credit_counter #(.MAX(ROB_SIZE)) u_rob (
        .clk(clk_in), .rst_n(rst_in), .en(rdy_in), .take(dispatch),
        .free(rob_free_in), .flush(flush_in), .cnt(rob_cnt), .nonzero(rob_nz)
    );

    credit_counter #(.MAX(RS_SIZE)) u_rs (
        .clk(clk_in), .rst_n(rst_in), .en(rdy_in), .take(rs_take),
        .free(rs_free_in), .flush(flush_in), .cnt(rs_cnt), .nonzero(rs_nz)
    );

    credit_counter #(.MAX(LSQ_SIZE)) u_lsq (
        .clk(clk_in), .rst_n(rst_in), .en(rdy_in), .take(lsq_take),
        .free(lsq_free_in), .flush(flush_in), .cnt(lsq_cnt), .nonzero(lsq_nz)
    );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based behavioural model.
module tb_dispatch_ctrl;
    import dispatch_pkg::*;

    localparam int PW = 85;
    localparam logic [5:0] T_ADD = 6'd0;
    localparam logic [5:0] T_LW  = OP_LB + 6'd2;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic       flush_in;
    logic       rob_free_in;
    logic       rs_free_in;
    logic       lsq_free_in;
    logic [1:0] state_out;

    dispatch_ctrl_if bus();

    dispatch_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rob_free_in(rob_free_in), .rs_free_in(rs_free_in), .lsq_free_in(lsq_free_in),
        .bus(bus), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    // Model: in-order packet queue, integer credit pools, state 0=RUN 1=STALL 2=RECOVER.
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] tx_q[$];
    int m_rob, m_rs, m_lsq, m_state;
    int n_checks = 0;
    int n_fail = 0;
    int disp_seen = 0;

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_p(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_rob = 16; m_rs = 16; m_lsq = 16; m_state = 0;
    endfunction

    function automatic logic [PW-1:0] mk_pkt(input logic [5:0] t);
        logic [PW-1:0] p;
        p = {t, 5'($urandom), 5'($urandom), 5'($urandom), 32'($urandom), 32'($urandom)};
        return p;
    endfunction

    always @(negedge clk_in) begin : compare
        logic [PW-1:0] head;
        logic e_ls, e_en, e_rdy;
        if (!rst_in) begin
            chk_i("rst_ready", int'(bus.dec_ready_out), 0);
            chk_i("rst_en", int'(bus.disp_en_out), 0);
            chk_p("rst_pkt", bus.disp_pkt_out, '0);
            chk_i("rst_state", int'(state_out), 0);
            model_reset();
        end else begin
            head  = (exp_q.size() > 0) ? exp_q[0] : '0;
            e_ls  = (exp_q.size() > 0) && (head[84:79] >= OP_LB) && (head[84:79] <= OP_SW);
            e_rdy = (exp_q.size() < 2) && (m_state != 2) && rdy_in && !flush_in;
            e_en  = (exp_q.size() > 0) && (m_rob > 0) && ((e_ls ? m_lsq : m_rs) > 0)
                    && (m_state != 2) && rdy_in && !flush_in;
            chk_i("ready", int'(bus.dec_ready_out), int'(e_rdy));
            chk_i("disp_en", int'(bus.disp_en_out), int'(e_en));
            chk_p("disp_pkt", bus.disp_pkt_out, head);
            chk_i("disp_is_ls", int'(bus.disp_is_ls_out), int'(e_ls));
            chk_i("state", int'(state_out), m_state);
            chk_i("rob_cnt", int'(dut.rob_cnt), m_rob);
            chk_i("rs_cnt", int'(dut.rs_cnt), m_rs);
            chk_i("lsq_cnt", int'(dut.lsq_cnt), m_lsq);
            if (bus.disp_en_out) disp_seen++;
            if (flush_in) begin
                exp_q.delete();
                m_rob = 16; m_rs = 16; m_lsq = 16; m_state = 2;
            end else if (rdy_in) begin
                if (m_state == 2) m_state = 0;
                else if (m_state == 0 && exp_q.size() > 0 && !e_en) m_state = 1;
                else if (m_state == 1 && e_en) m_state = 0;
                if (rob_free_in && m_rob < 16) m_rob++;
                if (rs_free_in && m_rs < 16) m_rs++;
                if (lsq_free_in && m_lsq < 16) m_lsq++;
                if (e_en) begin
                    void'(exp_q.pop_front());
                    m_rob--;
                    if (e_ls) m_lsq--; else m_rs--;
                end
                if (bus.dec_valid_in && e_rdy) exp_q.push_back(bus.dec_pkt_in);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_flush();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        idle(2);
    endtask

    task automatic drive_tx(input int bound);
        int cyc;
        cyc = 0;
        while (tx_q.size() > 0 && cyc < bound) begin
            bus.dec_valid_in = 1'b1;
            bus.dec_pkt_in   = tx_q[0];
            @(negedge clk_in);
            if (bus.dec_ready_out) void'(tx_q.pop_front());
            step();
            cyc++;
        end
        bus.dec_valid_in = 1'b0;
        chk_i("tx_drained", tx_q.size(), 0);
        tx_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        rob_free_in = 1'b0; rs_free_in = 1'b0; lsq_free_in = 1'b0;
        bus.dec_valid_in = 1'b0; bus.dec_pkt_in = '0;
        model_reset();
        idle(3);
        #1 rst_in = 1'b1;

        // Free pulses on full pools are dropped.
        step();
        rob_free_in = 1'b1; lsq_free_in = 1'b1;
        step();
        rob_free_in = 1'b0; lsq_free_in = 1'b0;
        chk_i("sat_rob", int'(dut.rob_cnt), 16);
        chk_i("sat_lsq", int'(dut.lsq_cnt), 16);

        // Three ALU packets back-to-back.
        base = disp_seen;
        for (int i = 0; i < 3; i++) tx_q.push_back(mk_pkt(T_ADD));
        drive_tx(10);
        idle(3);
        chk_i("alu3_disp", disp_seen - base, 3);
        chk_i("alu3_rob", int'(dut.rob_cnt), 13);
        chk_i("alu3_rs", int'(dut.rs_cnt), 13);

        // Sixteen loads exhaust ROB/LSQ; two more fill the FIFO.
        pulse_flush();
        base = disp_seen;
        for (int i = 0; i < 18; i++) tx_q.push_back(mk_pkt(T_LW));
        drive_tx(80);
        idle(3);
        chk_i("lw_disp16", disp_seen - base, 16);
        chk_i("lw_stall", int'(state_out), 1);
        chk_i("lw_full_ready", int'(bus.dec_ready_out), 0);
        chk_i("lw_lsq0", int'(dut.lsq_cnt), 0);
        rob_free_in = 1'b1; lsq_free_in = 1'b1;
        @(negedge clk_in);
        chk_i("lw_free_cycle_en", int'(bus.disp_en_out), 0);
        step();
        rob_free_in = 1'b0; lsq_free_in = 1'b0;
        @(negedge clk_in);
        chk_i("lw17_disp", int'(bus.disp_en_out), 1);
        step();
        chk_i("stall_exit", int'(state_out), 0);

        // Refill to full, then flush with a concurrent free.
        tx_q.push_back(mk_pkt(T_LW));
        drive_tx(10);
        chk_i("full_ready", int'(bus.dec_ready_out), 0);
        flush_in = 1'b1; rs_free_in = 1'b1;
        @(negedge clk_in);
        chk_i("flush_en", int'(bus.disp_en_out), 0);
        step();
        flush_in = 1'b0; rs_free_in = 1'b0;
        @(negedge clk_in);
        chk_i("recover_state", int'(state_out), 2);
        chk_p("recover_pkt", bus.disp_pkt_out, '0);
        chk_i("recover_rob", int'(dut.rob_cnt), 16);
        chk_i("recover_rs", int'(dut.rs_cnt), 16);
        chk_i("recover_lsq", int'(dut.lsq_cnt), 16);
        step();
        @(negedge clk_in);
        chk_i("recover_to_run", int'(state_out), 0);
        chk_i("recover_ready", int'(bus.dec_ready_out), 1);
        step();

        // ROB empty with RS credit left: ADD waits for a ROB free.
        for (int i = 0; i < 11; i++) tx_q.push_back(mk_pkt(T_ADD));
        for (int i = 0; i < 5; i++) tx_q.push_back(mk_pkt(T_LW));
        tx_q.push_back(mk_pkt(T_ADD));
        drive_tx(80);
        idle(3);
        chk_i("rob0_en", int'(bus.disp_en_out), 0);
        chk_i("rob0_rob", int'(dut.rob_cnt), 0);
        chk_i("rob0_rs", int'(dut.rs_cnt), 5);
        rob_free_in = 1'b1;
        step();
        rob_free_in = 1'b0;
        @(negedge clk_in);
        chk_i("rob_free_disp", int'(bus.disp_en_out), 1);
        step();
        chk_i("rob_after", int'(dut.rob_cnt), 0);
        chk_i("rs_after", int'(dut.rs_cnt), 4);

        // rdy_in low freezes a dispatchable head.
        pulse_flush();
        bus.dec_valid_in = 1'b1;
        bus.dec_pkt_in   = mk_pkt(T_ADD);
        step();
        bus.dec_valid_in = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            chk_i("rdy_low_en", int'(bus.disp_en_out), 0);
            chk_i("rdy_low_state", int'(state_out), 0);
            step();
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        chk_i("rdy_resume_en", int'(bus.disp_en_out), 1);
        step();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            flush_in    = ($urandom_range(0, 49) == 0);
            rob_free_in = (m_rob < 16) && ($urandom_range(0, 1) == 0);
            rs_free_in  = (m_rs < 16) && ($urandom_range(0, 2) == 0);
            lsq_free_in = (m_lsq < 16) && ($urandom_range(0, 2) == 0);
            bus.dec_valid_in = ($urandom_range(0, 3) != 0);
            bus.dec_pkt_in   = mk_pkt(6'($urandom_range(0, 20)));
            step();
        end
        rdy_in = 1'b1; flush_in = 1'b0;
        rob_free_in = 1'b0; rs_free_in = 1'b0; lsq_free_in = 1'b0;
        bus.dec_valid_in = 1'b0;
        step();

        // Asynchronous reset while stalled.
        pulse_flush();
        for (int i = 0; i < 17; i++) tx_q.push_back(mk_pkt(T_ADD));
        drive_tx(80);
        idle(3);
        chk_i("pre_rst_stall", int'(state_out), 1);
        rst_in = 1'b0;
        #1;
        chk_i("arst_state", int'(state_out), 0);
        chk_i("arst_en", int'(bus.disp_en_out), 0);
        chk_i("arst_ready", int'(bus.dec_ready_out), 0);
        chk_p("arst_pkt", bus.disp_pkt_out, '0);
        chk_i("arst_rob", int'(dut.rob_cnt), 16);
        chk_i("arst_rs", int'(dut.rs_cnt), 16);
        idle(2);
        #1;
        rst_in = 1'b1;
        bus.dec_valid_in = 1'b1;
        bus.dec_pkt_in   = mk_pkt(T_ADD);
        step();
        bus.dec_valid_in = 1'b0;
        @(negedge clk_in);
        chk_i("first_accept_disp", int'(bus.disp_en_out), 1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
